alg_amba_vip_base_delay_distr_loader: RTL

Programs the delay-distribution table of the AMBA VIP delay line from a compact configuration. On a start request it disables the delay line and writes all 256 table entries from a selectable profile. It then pulses the pointer reset with the seed and re-enables the line. It sits directly upstream of the delay line's `distr_*` port, between the testbench configuration registers and the delay line.

---
 rtl/alg_amba_vip_base_delay_distr_pkg.sv | 20 ++
 rtl/alg_amba_vip_base_lfsr16.sv | 25 ++
 rtl/alg_amba_vip_base_delay_distr_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alg_amba_vip_base_delay_distr_pkg.sv
// Shared types and helpers for the AMBA VIP delay-distribution table loader.
package alg_amba_vip_base_delay_distr_pkg;

  localparam int TABLE_WIDTH = 11;
  localparam int TABLE_DEPTH = 256;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    MODE_FIXED   = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_UNIFORM = 2'd2,
    MODE_BIMODAL = 2'd3
  } distr_mode_e;

  // Same polynomial as the delay line's table read LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[3] ^ l[12] ^ l[14] ^ l[15]};
  endfunction

endpackage

// File: rtl/alg_amba_vip_base_lfsr16.sv
// Seedable 16-bit LFSR; a zero seed would lock up, so it is replaced by a fixed one.
module alg_amba_vip_base_lfsr16
  import alg_amba_vip_base_delay_distr_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  // Load has priority over advance so a new sequence always starts from the seed.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/alg_amba_vip_base_delay_distr_loader.sv
// Loads all 256 delay-distribution entries of the delay line from a compact profile,
// then pulses the pointer reset and re-enables the line.
module alg_amba_vip_base_delay_distr_loader
  import alg_amba_vip_base_delay_distr_pkg::*;
#(
  parameter int DELAYLINE_OUTSTANDING_LOG2 = 6
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 cfg_start,
  input  logic [1:0]                           cfg_mode,
  input  logic [TABLE_WIDTH-1:0]               cfg_min,
  input  logic [TABLE_WIDTH-1:0]               cfg_max,
  input  logic [15:0]                          cfg_seed,
  input  logic [DELAYLINE_OUTSTANDING_LOG2-1:0] cfg_nbreq,
  input  logic                                 cfg_enable,
  output logic [15:0]                          distr_value,
  output logic                                 distr_write,
  output logic                                 distr_rstptr,
  output logic [15:0]                          distr_seed,
  output logic [DELAYLINE_OUTSTANDING_LOG2-1:0] distr_nbreq,
  output logic                                 distr_enable,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CNT_W = $clog2(TABLE_DEPTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_FILL,
    ST_RSTPTR,
    ST_ENABLE
  } state_e;

  state_e                 state_q, state_d;
  logic                   accept;
  logic                   gen;
  // Holds the index of the entry generated on the next edge; its MSB marks the end of FILL.
  logic [CNT_W-1:0]       cnt_q;
  distr_mode_e            mode_q;
  logic [TABLE_WIDTH-1:0] min_q, max_q;
  logic                   en_q;
  logic [15:0]            lfsr_state;
  logic [TABLE_WIDTH-1:0] range;
  logic [19:0]            ramp_prod, uni_prod;
  logic [TABLE_WIDTH-1:0] gen_value;

  alg_amba_vip_base_lfsr16 u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .load    (accept),
    .seed    (cfg_seed),
    .advance (gen),
    .state   (lfsr_state)
  );

  // Next-state logic; ENABLE behaves like IDLE so back-to-back loads lose no cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENABLE: begin
        if (cfg_start) begin
          state_d = ST_DISABLE;
          accept  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISABLE: state_d = ST_FILL;
      ST_FILL:    if (cnt_q == CNT_W'(TABLE_DEPTH)) state_d = ST_RSTPTR;
      ST_RSTPTR:  state_d = ST_ENABLE;
      default:    state_d = ST_IDLE;
    endcase
    gen = (state_d == ST_FILL);
  end

  // Entry value for the current index and LFSR state, registered into distr_value below.
  always_comb begin
    range     = max_q - min_q;
    ramp_prod = 20'(range) * 20'(cnt_q[7:0]);
    uni_prod  = (20'(range) + 20'd1) * 20'(lfsr_state & 16'h00FF);
    gen_value = min_q;
    unique case (mode_q)
      MODE_FIXED:   gen_value = min_q;
      MODE_RAMP:    gen_value = min_q + TABLE_WIDTH'(ramp_prod >> 8);
      MODE_UNIFORM: gen_value = min_q + TABLE_WIDTH'(uni_prod >> 8);
      MODE_BIMODAL: gen_value = lfsr_state[0] ? max_q : min_q;
      default:      gen_value = min_q;
    endcase
  end

  // FSM state, configuration capture and the index counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_FIXED;
      min_q   <= '0;
      max_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= '0;
        mode_q <= distr_mode_e'(cfg_mode);
        min_q  <= cfg_min;
        max_q  <= (cfg_max < cfg_min) ? cfg_min : cfg_max;
        en_q   <= cfg_enable;
      end else if (gen) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered outputs, derived from the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      distr_value  <= '0;
      distr_write  <= 1'b0;
      distr_rstptr <= 1'b0;
      distr_seed   <= '0;
      distr_nbreq  <= '0;
      distr_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      distr_write  <= gen;
      distr_rstptr <= (state_d == ST_RSTPTR);
      busy         <= (state_d == ST_DISABLE) || gen || (state_d == ST_RSTPTR);
      if (gen) distr_value <= {{(16 - TABLE_WIDTH){1'b0}}, gen_value};
      if (accept) begin
        distr_seed   <= cfg_seed;
        distr_nbreq  <= cfg_nbreq;
        distr_enable <= 1'b0;
        done         <= 1'b0;
      end else if (state_d == ST_ENABLE) begin
        distr_enable <= en_q;
        done         <= 1'b1;
      end
    end
  end

endmodule
